// File: rtl/clk_div_n.sv
// ============================================================================
// Module   : clk_div_n
// Brief    : Programmable clock-enable divider, one pulse every P+1 clk cycles.
//            Optional macro CLK_DIV_N_PRESCALE_LATCH_EN latches P per period.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_n #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] preScaleValue,
    output logic             slowEnPulse,
    output logic             slowEnPulse_d
);

    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             pulse_dly_q;
    logic [WIDTH-1:0] w_p;

`ifdef CLK_DIV_N_PRESCALE_LATCH_EN
    // Shadow copy of P: reloaded only at period boundaries so the running
    // period always finishes with the value it started with.
    logic [WIDTH-1:0] p_q;

    always_ff @(posedge clk) begin
        if (resetN) begin
            p_q <= preScaleValue;
        end else if (pulse_d) begin
            p_q <= preScaleValue;
        end
    end

    assign w_p = p_q;
`else
    assign w_p = preScaleValue;
`endif

    // The >= compare (not ==) makes a lowered P terminate the period at once.
    always_comb begin
        cnt_d   = cnt_q + c_ONE;
        pulse_d = 1'b0;
        if (cnt_q >= w_p) begin
            cnt_d   = c_ZERO;
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            cnt_q       <= c_ZERO;
            pulse_q     <= 1'b0;
            pulse_dly_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            pulse_dly_q <= pulse_q;
        end
    end

    assign slowEnPulse   = pulse_q;
    assign slowEnPulse_d = pulse_dly_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_n.sv
// ============================================================================
// Module   : tb_clk_div_n
// Brief    : Self-checking bench for clk_div_n (tables, corner sequences,
//            randomized run against a period-counting reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_n;

    localparam int WIDTH = 5;

    logic             clk;
    logic             resetN;
    logic [WIDTH-1:0] preScaleValue;
    logic             slowEnPulse;
    logic             slowEnPulse_d;

    int n_total;
    int n_bad;

    // Reference model state: cycles elapsed in the current period, the
    // divisor governing that period, and last two pulse values.
    int m_elapsed;
    int m_period_p;
    bit m_pulse;
    bit m_dly;

    typedef struct {
        bit             rst;
        int             p;
        bit             exp_pulse;
        bit             exp_dly;
    } vec_t;

    vec_t vecs[$];

    clk_div_n #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .preScaleValue (preScaleValue),
        .slowEnPulse   (slowEnPulse),
        .slowEnPulse_d (slowEnPulse_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input bit act, input bit exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s idx=%0d got=%0b expected=%0b", name, idx, act, exp);
        end
    endtask

    // Drive one edge; the model follows the behavioural rules: a period
    // ends when the elapsed count reaches the divisor in force.
    task automatic step(input bit rst, input int p);
        int eff;
        resetN        = rst;
        preScaleValue = WIDTH'(p);
        @(posedge clk);
        #1;
        if (rst) begin
            m_elapsed  = 0;
            m_pulse    = 0;
            m_dly      = 0;
            m_period_p = p;
        end else begin
`ifdef CLK_DIV_N_PRESCALE_LATCH_EN
            eff = m_period_p;
`else
            eff = p;
`endif
            m_dly = m_pulse;
            if (m_elapsed >= eff) begin
                m_elapsed  = 0;
                m_pulse    = 1;
                m_period_p = p;
            end else begin
                m_elapsed++;
                m_pulse = 0;
            end
        end
    endtask

    task automatic add_run(input int p, input int edges);
        vecs.push_back('{rst: 1'b1, p: p, exp_pulse: 1'b0, exp_dly: 1'b0});
        for (int e = 1; e <= edges; e++) begin
            vecs.push_back('{rst: 1'b0, p: p,
                             exp_pulse: ((e % (p + 1)) == 0),
                             exp_dly: (e >= p + 2) && (((e - 1) % (p + 1)) == 0)});
        end
    endtask

    initial begin
        int p_cur;
        n_total = 0;
        n_bad   = 0;
        resetN        = 1'b1;
        preScaleValue = '0;

        // Reset state
        step(1'b1, 4);
        step(1'b1, 4);
        check("reset_pulse", 0, slowEnPulse, 1'b0);
        check("reset_dly", 0, slowEnPulse_d, 1'b0);

        // Table-driven runs: P=4, P=7, P=0, P=31
        add_run(4, 99);
        add_run(7, 99);
        add_run(0, 20);
        add_run(31, 70);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].p);
            check("tbl_pulse", i, slowEnPulse, vecs[i].exp_pulse);
            check("tbl_dly", i, slowEnPulse_d, vecs[i].exp_dly);
        end

        // P lowered 7 -> 2 when cnt = 5
        step(1'b1, 7);
        for (int e = 1; e <= 5; e++) begin
            step(1'b0, 7);
            check("lower_pre", e, slowEnPulse, 1'b0);
        end
        for (int e = 6; e <= 16; e++) begin
            step(1'b0, 2);
`ifdef CLK_DIV_N_PRESCALE_LATCH_EN
            check("lower_pulse", e, slowEnPulse, (e == 8) || (e == 11) || (e == 14));
            check("lower_dly", e, slowEnPulse_d, (e == 9) || (e == 12) || (e == 15));
`else
            check("lower_pulse", e, slowEnPulse, (e == 6) || (e == 9) || (e == 12) || (e == 15));
            check("lower_dly", e, slowEnPulse_d, (e == 7) || (e == 10) || (e == 13) || (e == 16));
`endif
        end

        // P raised 2 -> 6 mid-count (cnt = 1): continue to new P
        step(1'b1, 2);
        step(1'b0, 2);
        for (int e = 2; e <= 14; e++) begin
            step(1'b0, 6);
`ifdef CLK_DIV_N_PRESCALE_LATCH_EN
            check("raise_pulse", e, slowEnPulse, (e == 3) || (e == 10));
`else
            check("raise_pulse", e, slowEnPulse, (e == 7) || (e == 14));
`endif
        end

        // Reset asserted at cnt = 3 with P = 4
        step(1'b1, 4);
        for (int e = 1; e <= 3; e++) step(1'b0, 4);
        step(1'b1, 4);
        check("midrst_pulse", 0, slowEnPulse, 1'b0);
        check("midrst_dly", 0, slowEnPulse_d, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, 4);
            check("midrst_after", e, slowEnPulse, (e == 5));
            check("midrst_after_dly", e, slowEnPulse_d, (e == 6));
        end

        // Randomized run against the model
        p_cur = 3;
        step(1'b1, p_cur);
        for (int i = 0; i < 800; i++) begin
            bit r;
            r = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) begin
                p_cur = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6))
                                                    : int'($urandom_range(0, 31));
            end
            step(r, p_cur);
            check("rnd_pulse", i, slowEnPulse, m_pulse);
            check("rnd_dly", i, slowEnPulse_d, m_dly);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clk_div_n.md
CLK_DIV_N -- requirements
Module: clk_div_n

Interface
REQ-001 Parameter: WIDTH, default 5, bit width of the prescale value and of the internal counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetN  input  1  reset; one clock; reset is synchronous and active-high (asserted = 1).
REQ-004 preScaleValue  input  WIDTH  unsigned divide setting P; pulse period is P+1 clk cycles.
REQ-005 slowEnPulse  output  1  registered one-cycle enable pulse, once per P+1 cycles.
REQ-006 slowEnPulse_d  output  1  slowEnPulse delayed by exactly one clk cycle (registered).

Function
REQ-007 The block SHALL hold an internal WIDTH-bit counter cnt, unsigned.
REQ-008 Each rising edge with reset deasserted: if cnt >= P, the block SHALL set cnt to 0 and slowEnPulse to 1; else it SHALL increment cnt by 1 and set slowEnPulse to 0.
REQ-009 The block SHALL set slowEnPulse_d to the value slowEnPulse held before the edge.
REQ-010 Latency: first slowEnPulse SHALL be high on the (P+1)th edge after reset release, then every P+1 edges; slowEnPulse_d high on the (P+2)th edge, then every P+1 edges.
REQ-011 slowEnPulse SHALL never be high on two consecutive cycles unless P = 0.
REQ-012 P = 0: slowEnPulse SHALL be high every cycle after the first edge; slowEnPulse_d high every cycle from the second edge.
REQ-013 P = 2^WIDTH-1: period SHALL be 2^WIDTH cycles; cnt never overflows (the >= compare wraps it).
REQ-014 P lowered mid-count below cnt: the >= compare SHALL fire on the next edge (pulse, cnt to 0), with no 2^WIDTH-cycle runaway.
REQ-015 P raised mid-count: counting SHALL continue from the current cnt to the new P.
REQ-016 Both outputs SHALL be driven directly from flip-flops, with no combinational path from inputs.

Reset
REQ-017 While resetN = 1 at a rising edge: cnt = 0, slowEnPulse = 0, slowEnPulse_d = 0.
REQ-018 Reset asserted mid-period SHALL abort the period; counting restarts per REQ-010 after release.
REQ-019 Reset SHALL take priority over all counting logic on the same edge.

Configuration
REQ-020 Macro CLK_DIV_N_PRESCALE_LATCH_EN defined: P SHALL be a WIDTH-bit shadow register, loaded from preScaleValue at reset and on every edge where slowEnPulse is set to 1; mid-period preScaleValue changes take effect from the next period only, so REQ-014/015 do not apply.
REQ-021 Macro undefined: P SHALL be preScaleValue directly (live), with REQ-014/015 applying.

Verification
REQ-022 Reset, P=4, 99 edges: slowEnPulse high exactly at edges 5,10,15,...,95; slowEnPulse_d high exactly at 6,11,...,96; all others 0.
REQ-023 Re-reset, P=7, 99 edges: slowEnPulse high at edges 8,16,...,96; slowEnPulse_d high at 9,17,...,97.
REQ-024 P=0: both outputs 1 every cycle after the initial 1/2-edge latency; P=31 (WIDTH=5): pulse every 32 edges.
REQ-025 P=7, change to 2 when cnt=5 (macro undefined): pulse on next edge, then every 3 edges; macro defined: completes 8-cycle period, then every 3.
REQ-026 Assert resetN at cnt=3 with P=4: outputs 0 on that edge; next pulse at 5th edge after release.
